// File: rtl/tm1638_stimulus_keys_counter_n_if.sv
// Frame channel between the key-counter stimulus and the TM1638 driver.
// Latency: none, plain wires.
// Backpressure: o_Valid/o_Segments/o_Leds held by the master until i_Ready.
interface tm1638_stimulus_keys_counter_n_if;
  logic [7:0][7:0] o_Segments;  // [grid][segment], bin2led7 encoding
  logic [7:0]      o_Leds;      // [grid]
  logic            o_Valid;
  logic            i_Ready;

  modport master (output o_Segments, output o_Leds, output o_Valid, input i_Ready);
  modport slave  (input o_Segments, input o_Leds, input o_Valid, output i_Ready);
endinterface

// File: rtl/tm1638_stimulus_keys_counter_n.sv
// Key-to-counter stimulus: per-digit modulo counters stepped by key pulses and hold-to-repeat, framed for the driver.
// Latency: count updates on the key edge; o_Valid rises on the next edge when the output FSM is idle.
// Backpressure: a frame is held until i_Ready; changes while pending coalesce into exactly one follow-up frame.
module tm1638_stimulus_keys_counter_n #(
  parameter int         NUM_DIGITS           = 8,
  parameter int         SPI_READ_WIDTH       = 32,
  parameter int         COUNT_MODULUS        = 16,
  parameter logic [7:0] DIR_MASK             = 8'h00,
  parameter int         REPEAT_DELAY_CYCLES  = 0,
  parameter int         REPEAT_PERIOD_CYCLES = 1,
  parameter int         REFRESH_CLK_CYCLES   = 0,
  parameter int         LED_MODE             = 0
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic [SPI_READ_WIDTH-1:0] i_Data_Pulse,
  input  logic [SPI_READ_WIDTH-1:0] i_Data_Level,
  input  logic                      i_Clear,
  tm1638_stimulus_keys_counter_n_if.master frame_if
);

  // Key bit i drives digit i; only the first eight key bits can map to a grid.
  localparam logic [3:0]  LAST    = 4'(COUNT_MODULUS - 1);
  localparam logic [31:0] DLY_END = 32'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [31:0] PER_END = 32'(REPEAT_PERIOD_CYCLES - 1);
  localparam logic [31:0] REF_END = 32'(REFRESH_CLK_CYCLES - 1);

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_e;
  typedef enum logic       {OUT_IDLE, OUT_PEND} out_state_e;

  rpt_state_e      rpt_q [8];
  rpt_state_e      rpt_d [8];
  logic [31:0]     rtmr_q [8];
  logic [31:0]     rtmr_d [8];
  logic [3:0]      cnt_q [8];
  logic [3:0]      cnt_d [8];
  logic [7:0]      step;
  out_state_e      out_q, out_d;
  logic [7:0][7:0] seg_q, seg_d;
  logic [7:0]      led_q, led_d;
  logic            vld_q, vld_d;
  logic            dirty_q, dirty_d;
  logic [31:0]     ref_q, ref_d;
  logic            snap;
  logic [7:0][7:0] frame_seg;
  logic [7:0]      frame_led;

  logic unused_keys;
  assign unused_keys = ^{i_Data_Pulse[SPI_READ_WIDTH-1:8], i_Data_Level[SPI_READ_WIDTH-1:8]};

  function automatic logic [7:0] bin2led7(input logic [3:0] v);
    logic [7:0] r;
    r = 8'h00;
    case (v)
      4'h0: r = 8'h3F;  4'h1: r = 8'h06;  4'h2: r = 8'h5B;  4'h3: r = 8'h4F;
      4'h4: r = 8'h66;  4'h5: r = 8'h6D;  4'h6: r = 8'h7D;  4'h7: r = 8'h07;
      4'h8: r = 8'h7F;  4'h9: r = 8'h6F;  4'hA: r = 8'h77;  4'hB: r = 8'h7C;
      4'hC: r = 8'h39;  4'hD: r = 8'h5E;  4'hE: r = 8'h79;  4'hF: r = 8'h71;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] step_val(input logic [3:0] v, input logic down);
    logic [3:0] r;
    if (down) r = (v == 4'd0) ? LAST : v - 4'd1;
    else      r = (v == LAST) ? 4'd0 : v + 4'd1;
    return r;
  endfunction

  // Per-digit repeat FSMs and counters; clear overrides any step on the same edge.
  always_comb begin
    step = '0;
    for (int i = 0; i < 8; i++) begin
      rpt_d[i]  = rpt_q[i];
      rtmr_d[i] = rtmr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (i < NUM_DIGITS) begin
        case (rpt_q[i])
          RPT_IDLE: begin
            if (i_Data_Pulse[i]) begin
              step[i]   = 1'b1;
              rtmr_d[i] = '0;
              if (REPEAT_DELAY_CYCLES != 0) rpt_d[i] = RPT_DELAY;
            end
          end
          RPT_DELAY: begin
            if (!i_Data_Level[i]) begin
              rpt_d[i] = RPT_IDLE;
            end else if (rtmr_q[i] == DLY_END) begin
              step[i]   = 1'b1;
              rtmr_d[i] = '0;
              rpt_d[i]  = RPT_REPEAT;
            end else begin
              rtmr_d[i] = rtmr_q[i] + 32'd1;
            end
          end
          RPT_REPEAT: begin
            if (!i_Data_Level[i]) begin
              rpt_d[i] = RPT_IDLE;
            end else if (rtmr_q[i] == PER_END) begin
              step[i]   = 1'b1;
              rtmr_d[i] = '0;
            end else begin
              rtmr_d[i] = rtmr_q[i] + 32'd1;
            end
          end
          default: rpt_d[i] = RPT_IDLE;
        endcase
        if (step[i]) cnt_d[i] = step_val(cnt_q[i], DIR_MASK[i]);
      end
      if (i_Clear) begin
        cnt_d[i] = '0;
        rpt_d[i] = RPT_IDLE;
      end
    end
  end

  // Frame content built from the pre-edge counts; inactive grids stay blank and dark.
  always_comb begin
    frame_seg = '0;
    frame_led = '0;
    for (int g = 0; g < 8; g++) begin
      if (g < NUM_DIGITS) begin
        frame_seg[g] = bin2led7(cnt_q[g]);
        frame_led[g] = (LED_MODE == 1) ? i_Data_Level[g] : (cnt_q[g] != 4'd0);
      end
    end
  end

  // Output FSM: snapshot on dirty or refresh expiry, hold until accepted.
  always_comb begin
    out_d = out_q;
    seg_d = seg_q;
    led_d = led_q;
    vld_d = vld_q;
    ref_d = ref_q;
    snap  = 1'b0;
    case (out_q)
      OUT_IDLE: begin
        if (dirty_q || (REFRESH_CLK_CYCLES != 0 && ref_q == REF_END)) begin
          snap  = 1'b1;
          seg_d = frame_seg;
          led_d = frame_led;
          vld_d = 1'b1;
          ref_d = '0;
          out_d = OUT_PEND;
        end else if (REFRESH_CLK_CYCLES != 0) begin
          ref_d = ref_q + 32'd1;
        end
      end
      OUT_PEND: begin
        if (vld_q && frame_if.i_Ready) begin
          vld_d = 1'b0;
          out_d = OUT_IDLE;
        end
      end
      default: out_d = OUT_IDLE;
    endcase
    // A step on the snapshot edge is not in that frame, so it must keep dirty set.
    dirty_d = (dirty_q & ~snap) | (|step) | i_Clear;
  end

  // All state advances on the falling clock edge.
  always_ff @(negedge i_Clk) begin
    if (i_Rst) begin
      for (int i = 0; i < 8; i++) begin
        rpt_q[i]  <= RPT_IDLE;
        rtmr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      out_q   <= OUT_IDLE;
      seg_q   <= '0;
      led_q   <= '0;
      vld_q   <= 1'b0;
      ref_q   <= '0;
      dirty_q <= 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        rpt_q[i]  <= rpt_d[i];
        rtmr_q[i] <= rtmr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      out_q   <= out_d;
      seg_q   <= seg_d;
      led_q   <= led_d;
      vld_q   <= vld_d;
      ref_q   <= ref_d;
      dirty_q <= dirty_d;
    end
  end

  assign frame_if.o_Segments = seg_q;
  assign frame_if.o_Leds     = led_q;
  assign frame_if.o_Valid    = vld_q;

endmodule

// File: tb/tb_tm1638_stimulus_keys_counter_n.sv
// Bench for the key-counter stimulus: two instances with different parameter sets, checked against a count model.
// Latency: inputs driven 1 time unit after the rising edge, DUT acts on the falling edge, outputs sampled on rising.
// Backpressure: i_Ready is held low in the back-pressure and mid-frame reset scenarios, high elsewhere.
module tb_tm1638_stimulus_keys_counter_n;

  // Instance A: decimal, digit 0 counts down, auto-repeat 5/2, no refresh, count LEDs.
  localparam int A_MOD = 10, A_DLY = 5, A_PER = 2;
  // Instance B: hex, six digits, no repeat, refresh every 50 idle cycles, key-level LEDs.
  localparam int B_MOD = 16, B_DIG = 6, B_REF = 50;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic [31:0] pulse_a = '0, level_a = '0, pulse_b = '0, level_b = '0;
  logic        clear_a = 1'b0, clear_b = 1'b0;

  int total = 0, bad = 0, cyc = 0;
  int ma [8];
  int mb [8];

  tm1638_stimulus_keys_counter_n_if ifa ();
  tm1638_stimulus_keys_counter_n_if ifb ();

  tm1638_stimulus_keys_counter_n #(
    .NUM_DIGITS(8), .SPI_READ_WIDTH(32), .COUNT_MODULUS(A_MOD), .DIR_MASK(8'h01),
    .REPEAT_DELAY_CYCLES(A_DLY), .REPEAT_PERIOD_CYCLES(A_PER), .REFRESH_CLK_CYCLES(0), .LED_MODE(0)
  ) dut_a (
    .i_Clk(clk), .i_Rst(rst_a), .i_Data_Pulse(pulse_a), .i_Data_Level(level_a),
    .i_Clear(clear_a), .frame_if(ifa)
  );

  tm1638_stimulus_keys_counter_n #(
    .NUM_DIGITS(B_DIG), .SPI_READ_WIDTH(32), .COUNT_MODULUS(B_MOD), .DIR_MASK(8'h00),
    .REPEAT_DELAY_CYCLES(0), .REPEAT_PERIOD_CYCLES(1), .REFRESH_CLK_CYCLES(B_REF), .LED_MODE(1)
  ) dut_b (
    .i_Clk(clk), .i_Rst(rst_b), .i_Data_Pulse(pulse_b), .i_Data_Level(level_b),
    .i_Clear(clear_b), .frame_if(ifb)
  );

  always #5 clk = ~clk;

  // Frame monitor: every rising o_Valid is a new frame (o_Valid is low between frames).
  int              fr_a = 0, fr_b = 0, rise_b = 0;
  logic            pv_a = 1'b0, pv_b = 1'b0;
  logic [7:0][7:0] lseg_a = '0, lseg_b = '0;
  logic [7:0]      lled_a = '0, lled_b = '0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ifa.o_Valid === 1'b1 && pv_a !== 1'b1) begin
      fr_a = fr_a + 1; lseg_a = ifa.o_Segments; lled_a = ifa.o_Leds;
    end
    if (ifb.o_Valid === 1'b1 && pv_b !== 1'b1) begin
      fr_b = fr_b + 1; lseg_b = ifb.o_Segments; lled_b = ifb.o_Leds; rise_b = cyc;
    end
    pv_a = ifa.o_Valid;
    pv_b = ifb.o_Valid;
  end

  function automatic logic [7:0] seg7(input int v);
    logic [7:0] r;
    case (v)
      0: r = 8'h3F;  1: r = 8'h06;  2: r = 8'h5B;  3: r = 8'h4F;
      4: r = 8'h66;  5: r = 8'h6D;  6: r = 8'h7D;  7: r = 8'h07;
      8: r = 8'h7F;  9: r = 8'h6F;  10: r = 8'h77; 11: r = 8'h7C;
      12: r = 8'h39; 13: r = 8'h5E; 14: r = 8'h79; 15: r = 8'h71;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0][7:0] exp_seg_a();
    logic [7:0][7:0] r;
    for (int g = 0; g < 8; g++) r[g] = seg7(ma[g]);
    return r;
  endfunction

  function automatic logic [7:0] exp_led_a();
    logic [7:0] r;
    for (int g = 0; g < 8; g++) r[g] = (ma[g] != 0);
    return r;
  endfunction

  function automatic logic [7:0][7:0] exp_seg_b();
    logic [7:0][7:0] r;
    for (int g = 0; g < 8; g++) r[g] = (g < B_DIG) ? seg7(mb[g]) : 8'h00;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press key d on A: pulse plus level held for 'hold' edges, then one edge released.
  // Steps land at t0 and at t0 + DLY + k*PER while still held.
  task automatic press_a(input int d, input int hold);
    int s;
    pulse_a = 32'd1 << d;
    level_a = 32'd1 << d;
    tick();
    pulse_a = '0;
    repeat (hold - 1) tick();
    level_a = '0;
    tick();
    s = 1;
    if (hold - 1 >= A_DLY) s = s + 1 + (hold - 1 - A_DLY) / A_PER;
    if (d == 0) ma[d] = (ma[d] + A_MOD * 4 - s) % A_MOD;
    else        ma[d] = (ma[d] + s) % A_MOD;
  endtask

  task automatic press_b(input int d);
    pulse_b = 32'd1 << d;
    tick();
    pulse_b = '0;
    tick();
    if (d < B_DIG) mb[d] = (mb[d] + 1) % B_MOD;
  endtask

  task automatic test_reset();
    int f0a, f0b;
    ifa.i_Ready = 1'b1;
    ifb.i_Ready = 1'b1;
    foreach (ma[i]) ma[i] = 0;
    foreach (mb[i]) mb[i] = 0;
    repeat (3) tick();
    total++; if (ifa.o_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid_a: got %b want 0", ifa.o_Valid); end
    total++; if (ifa.o_Segments !== 64'h0) begin bad++; $display("FAIL rst_seg_a: got %h want 0", ifa.o_Segments); end
    total++; if (ifb.o_Leds !== 8'h00) begin bad++; $display("FAIL rst_led_b: got %h want 00", ifb.o_Leds); end
    f0a = fr_a; f0b = fr_b;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (10) tick();
    total++; if (fr_a - f0a !== 1) begin bad++; $display("FAIL rst_frames_a: got %0d want 1", fr_a - f0a); end
    total++; if (lseg_a !== exp_seg_a()) begin bad++; $display("FAIL rst_frame_seg_a: got %h want %h", lseg_a, exp_seg_a()); end
    total++; if (lled_a !== 8'h00) begin bad++; $display("FAIL rst_frame_led_a: got %h want 00", lled_a); end
    total++; if (ifa.o_Valid !== 1'b0) begin bad++; $display("FAIL rst_quiet_a: got %b want 0", ifa.o_Valid); end
    total++; if (fr_b - f0b !== 1) begin bad++; $display("FAIL rst_frames_b: got %0d want 1", fr_b - f0b); end
    total++; if (lseg_b !== exp_seg_b()) begin bad++; $display("FAIL rst_frame_seg_b: got %h want %h", lseg_b, exp_seg_b()); end
  endtask

  task automatic test_wrap();
    repeat (3) press_a(2, 1);
    repeat (3) tick();
    total++; if (lseg_a[2] !== seg7(3)) begin bad++; $display("FAIL wrap_three: got %h want %h", lseg_a[2], seg7(3)); end
    total++; if (lled_a !== exp_led_a()) begin bad++; $display("FAIL wrap_led: got %h want %h", lled_a, exp_led_a()); end
    repeat (10) press_a(2, 1);
    repeat (3) tick();
    total++; if (lseg_a !== exp_seg_a() || ma[2] != 3) begin bad++; $display("FAIL wrap_thirteen: got %h want %h", lseg_a, exp_seg_a()); end
  endtask

  task automatic test_down();
    press_a(0, 1);
    repeat (3) tick();
    total++; if (lseg_a[0] !== seg7(9)) begin bad++; $display("FAIL down_wrap: got %h want %h", lseg_a[0], seg7(9)); end
    total++; if (lled_a[0] !== 1'b1) begin bad++; $display("FAIL down_led: got %b want 1", lled_a[0]); end
  endtask

  task automatic test_repeat();
    press_a(1, 12);
    repeat (4) tick();
    total++; if (lseg_a[1] !== seg7(5) || ma[1] != 5) begin bad++; $display("FAIL repeat_hold12: got %h want %h", lseg_a[1], seg7(5)); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      press_a($urandom_range(0, 7), $urandom_range(1, 14));
      repeat (4) tick();
      total++;
      if (lseg_a !== exp_seg_a() || lled_a !== exp_led_a()) begin
        bad++; $display("FAIL random_%0d: got %h/%h want %h/%h", k, lseg_a, lled_a, exp_seg_a(), exp_led_a());
      end
    end
  endtask

  task automatic test_back_to_back();
    int f0, lows;
    logic [7:0][7:0] held;
    ifa.i_Ready = 1'b0;
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    foreach (ma[i]) ma[i] = 0;
    repeat (3) tick();
    f0 = fr_a; held = ifa.o_Segments; lows = 0;
    for (int k = 0; k < 4; k++) begin
      press_a(3, 1);
      if (ifa.o_Valid !== 1'b1) lows++;
    end
    repeat (12) begin tick(); if (ifa.o_Valid !== 1'b1) lows++; end
    total++; if (lows != 0) begin bad++; $display("FAIL bp_valid_held: got %0d low samples want 0", lows); end
    total++; if (ifa.o_Segments !== held || held[3] !== seg7(0)) begin bad++; $display("FAIL bp_frame_stable: got %h want %h", ifa.o_Segments, held); end
    total++; if (fr_a != f0) begin bad++; $display("FAIL bp_no_new_frame: got %0d want %0d", fr_a, f0); end
    ifa.i_Ready = 1'b1;
    tick();
    total++; if (ifa.o_Valid !== 1'b0) begin bad++; $display("FAIL bp_gap: got %b want 0", ifa.o_Valid); end
    repeat (8) tick();
    total++; if (fr_a - f0 != 1) begin bad++; $display("FAIL bp_one_frame: got %0d want 1", fr_a - f0); end
    total++; if (lseg_a[3] !== seg7(4) || lseg_a !== exp_seg_a()) begin bad++; $display("FAIL bp_latest: got %h want %h", lseg_a, exp_seg_a()); end
  endtask

  task automatic test_reset_midframe();
    int f0;
    press_a(5, 1);
    ifa.i_Ready = 1'b0;
    press_a(5, 1);
    tick();
    total++; if (ifa.o_Valid !== 1'b1) begin bad++; $display("FAIL mid_pending: got %b want 1", ifa.o_Valid); end
    rst_a = 1'b1;
    tick();
    total++; if (ifa.o_Valid !== 1'b0) begin bad++; $display("FAIL mid_drop: got %b want 0", ifa.o_Valid); end
    tick();
    rst_a = 1'b0;
    foreach (ma[i]) ma[i] = 0;
    ifa.i_Ready = 1'b1;
    f0 = fr_a;
    repeat (5) tick();
    total++; if (fr_a - f0 != 1) begin bad++; $display("FAIL mid_resend: got %0d want 1", fr_a - f0); end
    total++; if (lseg_a !== exp_seg_a()) begin bad++; $display("FAIL mid_resend_seg: got %h want %h", lseg_a, exp_seg_a()); end
  endtask

  task automatic test_clear();
    int f0;
    repeat (7) press_b(4);
    repeat (3) tick();
    total++; if (lseg_b[4] !== seg7(7)) begin bad++; $display("FAIL clr_pre: got %h want %h", lseg_b[4], seg7(7)); end
    f0 = fr_b;
    clear_b = 1'b1;
    pulse_b = 32'h10;
    tick();
    clear_b = 1'b0;
    pulse_b = '0;
    foreach (mb[i]) mb[i] = 0;
    repeat (4) tick();
    total++; if (fr_b == f0) begin bad++; $display("FAIL clr_frame: got %0d frames want >=1", fr_b - f0); end
    total++; if (lseg_b !== exp_seg_b()) begin bad++; $display("FAIL clr_wins: got %h want %h", lseg_b, exp_seg_b()); end
  endtask

  task automatic test_refresh();
    int f0, n, t1, t2;
    level_b = 32'h82;
    f0 = fr_b; n = 0;
    while (fr_b == f0 && n < 120) begin tick(); n++; end
    total++; if (fr_b == f0) begin bad++; $display("FAIL ref_timeout1: got no frame within %0d cycles", n); end
    total++; if (lled_b !== 8'h02) begin bad++; $display("FAIL ref_led_level: got %h want 02", lled_b); end
    total++; if (lseg_b !== exp_seg_b()) begin bad++; $display("FAIL ref_seg: got %h want %h", lseg_b, exp_seg_b()); end
    // Key 7 maps to an inactive digit and must not trigger a frame.
    f0 = fr_b;
    pulse_b = 32'h80;
    tick();
    pulse_b = '0;
    repeat (20) tick();
    total++; if (fr_b != f0) begin bad++; $display("FAIL ref_inactive_key: got %0d frames want 0", fr_b - f0); end
    f0 = fr_b; n = 0;
    while (fr_b == f0 && n < 120) begin tick(); n++; end
    t1 = rise_b;
    f0 = fr_b; n = 0;
    while (fr_b == f0 && n < 120) begin tick(); n++; end
    t2 = rise_b;
    // 50 idle edges, plus the one accept edge spent in PEND.
    total++; if (t2 - t1 != B_REF + 1) begin bad++; $display("FAIL ref_period: got %0d want %0d", t2 - t1, B_REF + 1); end
    level_b = '0;
  endtask

  initial begin
    ifa.i_Ready = 1'b1;
    ifb.i_Ready = 1'b1;
    test_reset();
    test_wrap();
    test_down();
    test_repeat();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    test_clear();
    test_refresh();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
